led_pattern_gen: RTL and testbench

Parametrised LED pattern generator: drives an `N_LED`-wide one-hot LED bus that advances one position per prescaler tick in one of four patterns. Supports pause and single-step. It sits directly on the board LED pins in the demo top level and replaces the fixed 8-LED, two-mode chaser. The interleave pattern is corrected to visit every LED exactly once per period.

---
 rtl/led_pattern_gen.sv | 149 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Brief    : One-hot LED pattern generator with four patterns and pause/step.
// Revision : 1.0 - initial release
// ============================================================================

module led_pattern_gen #(
  parameter int N_LED    = 8,
  parameter int TICK_DIV = 500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     step,
  input  logic [1:0]               mode,
  output logic [N_LED-1:0]         led,
  output logic [$clog2(N_LED)-1:0] pos,
  output logic                     tick
);

  localparam int c_pos_w  = $clog2(N_LED);
  localparam int c_wide_w = c_pos_w + 1;
  localparam int c_cnt_w  = $clog2(TICK_DIV);

  localparam logic [c_cnt_w-1:0]  c_cnt_max = c_cnt_w'(TICK_DIV - 1);
  localparam logic [c_wide_w-1:0] c_last    = c_wide_w'(N_LED - 1);
  localparam logic [c_wide_w-1:0] c_one     = c_wide_w'(1);
  localparam logic [c_wide_w-1:0] c_two     = c_wide_w'(2);
  localparam logic [N_LED-1:0]    c_led_one = {{(N_LED-1){1'b0}}, 1'b1};

  localparam logic [1:0] c_mode_left   = 2'd0;
  localparam logic [1:0] c_mode_right  = 2'd1;
  localparam logic [1:0] c_mode_bounce = 2'd2;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [c_cnt_w-1:0]  cnt_q,  cnt_d;
  logic [c_pos_w-1:0]  pos_q,  pos_d;
  logic [N_LED-1:0]    led_q,  led_d;
  logic                tick_q, tick_d;
  dir_e                dir_q,  dir_d;
  logic [1:0]          mode_q, mode_d;

  logic                w_adv;
  logic [c_wide_w-1:0] w_pos_wide;
  logic [c_wide_w-1:0] w_nxt_wide;
  logic                w_unused_msb;

  assign w_pos_wide   = {1'b0, pos_q};
  assign w_unused_msb = w_nxt_wide[c_pos_w];

  // Prescaler freezes while paused; step only counts when paused.
  always_comb begin
    cnt_d = cnt_q;
    w_adv = 1'b0;
    if (en) begin
      if (cnt_q == c_cnt_max) begin
        cnt_d = '0;
        w_adv = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      w_adv = step;
    end
  end

  always_comb begin
    w_nxt_wide = w_pos_wide;
    dir_d      = dir_q;
    mode_d     = mode_q;
    if (w_adv) begin
      if (mode != mode_q) begin
        // A new pattern restarts from LED 0 instead of stepping.
        mode_d     = mode;
        w_nxt_wide = '0;
        dir_d      = DIR_UP;
      end else begin
        case (mode_q)
          c_mode_left: begin
            w_nxt_wide = (w_pos_wide == c_last) ? '0 : w_pos_wide + 1'b1;
          end
          c_mode_right: begin
            w_nxt_wide = (w_pos_wide == '0) ? c_last : w_pos_wide - 1'b1;
          end
          c_mode_bounce: begin
            if (dir_q == DIR_UP) begin
              if (w_pos_wide == c_last) begin
                w_nxt_wide = c_last - 1'b1;
                dir_d      = DIR_DOWN;
              end else begin
                w_nxt_wide = w_pos_wide + 1'b1;
              end
            end else begin
              if (w_pos_wide == '0) begin
                w_nxt_wide = c_one;
                dir_d      = DIR_UP;
              end else begin
                w_nxt_wide = w_pos_wide - 1'b1;
              end
            end
          end
          default: begin
            // Interleave: evens ascending, then odds ascending.
            if (w_pos_wide + c_two <= c_last) begin
              w_nxt_wide = w_pos_wide + c_two;
            end else if (!pos_q[0]) begin
              w_nxt_wide = c_one;
            end else begin
              w_nxt_wide = '0;
            end
          end
        endcase
      end
    end
    pos_d  = w_nxt_wide[c_pos_w-1:0];
    led_d  = c_led_one << pos_d;
    tick_d = w_adv;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      led_q  <= c_led_one;
      tick_q <= 1'b0;
      dir_q  <= DIR_UP;
      mode_q <= c_mode_left;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      led_q  <= led_d;
      tick_q <= tick_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
    end
  end

  assign led  = led_q;
  assign pos  = pos_q;
  assign tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_gen
// Brief    : Scoreboard bench for led_pattern_gen (N_LED 8 and 5, TICK_DIV 4).
// Revision : 1.0 - initial release
// ============================================================================

module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       step;
  logic [1:0] mode;
  logic [7:0] led8;
  logic [2:0] pos8;
  logic       tick8;
  logic [4:0] led5;
  logic [2:0] pos5;
  logic       tick5;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   pos;
    logic tick;
    int   pos5;
    bit   chk5;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  led_pattern_gen #(.N_LED(8), .TICK_DIV(4)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .step (step),
    .mode (mode),
    .led  (led8),
    .pos  (pos8),
    .tick (tick8)
  );

  led_pattern_gen #(.N_LED(5), .TICK_DIV(4)) u_dut5 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .step (step),
    .mode (mode),
    .led  (led5),
    .pos  (pos5),
    .tick (tick5)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; en = 1'b1; step = 1'b0; mode = 2'd0;
    for (int c = 1; c <= 3; c++) begin
      sb.push_back('{pos: 0, tick: 1'b0, pos5: 0, chk5: 1'b1});
      cyc();
      e = sb.pop_front();
      checks++;
      if (pos8 !== 3'(e.pos) || led8 !== 8'(1 << e.pos) || tick8 !== e.tick ||
          pos5 !== 3'(e.pos5) || led5 !== 5'(1 << e.pos5) || tick5 !== e.tick) begin
        errors++;
        $display("FAIL reset c=%0d: got pos=%0d led=%h tick=%b pos5=%0d led5=%h, want pos=0 led=01 tick=0 pos5=0 led5=01",
                 c, pos8, led8, tick8, pos5, led5);
      end
    end
  endtask

  task automatic test_rotate_left();
    exp_t e;
    int   p = 0;
    logic t;
    mode = 2'd0; en = 1'b1; step = 1'b0;
    do_reset();
    for (int c = 1; c <= 36; c++) begin
      t = 1'b0;
      if (c % 4 == 0) begin
        p = (p + 1) % 8;
        t = 1'b1;
      end
      sb.push_back('{pos: p, tick: t, pos5: 0, chk5: 1'b0});
      cyc();
      e = sb.pop_front();
      checks++;
      if (pos8 !== 3'(e.pos) || led8 !== 8'(1 << e.pos) || tick8 !== e.tick) begin
        errors++;
        $display("FAIL rotate_left c=%0d: got pos=%0d led=%h tick=%b, want pos=%0d led=%h tick=%b",
                 c, pos8, led8, tick8, e.pos, 8'(1 << e.pos), e.tick);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    int   p = 0;
    int   k = 0;
    logic t;
    int   bseq[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    mode = 2'd0; en = 1'b1; step = 1'b0;
    do_reset();
    for (int c = 1; c <= 68; c++) begin
      if (c == 7) mode = 2'd2;
      t = 1'b0;
      if (c == 4) begin
        p = 1; t = 1'b1;
      end else if (c == 8) begin
        p = 0; t = 1'b1;
      end else if (c > 8 && c % 4 == 0) begin
        p = bseq[k]; k++; t = 1'b1;
      end
      sb.push_back('{pos: p, tick: t, pos5: 0, chk5: 1'b0});
      cyc();
      e = sb.pop_front();
      checks++;
      if (pos8 !== 3'(e.pos) || led8 !== 8'(1 << e.pos) || tick8 !== e.tick) begin
        errors++;
        $display("FAIL bounce c=%0d: got pos=%0d led=%h tick=%b, want pos=%0d led=%h tick=%b",
                 c, pos8, led8, tick8, e.pos, 8'(1 << e.pos), e.tick);
      end
    end
  endtask

  task automatic test_interleave();
    exp_t e;
    int   p = 0;
    int   q = 0;
    int   k = 0;
    logic t;
    int   iseq8[8] = '{2, 4, 6, 1, 3, 5, 7, 0};
    int   iseq5[8] = '{2, 4, 1, 3, 0, 2, 4, 1};
    mode = 2'd0; en = 1'b1; step = 1'b0;
    do_reset();
    mode = 2'd3;
    for (int c = 1; c <= 36; c++) begin
      t = 1'b0;
      if (c == 4) begin
        p = 0; q = 0; t = 1'b1;
      end else if (c > 4 && c % 4 == 0) begin
        p = iseq8[k]; q = iseq5[k]; k++; t = 1'b1;
      end
      sb.push_back('{pos: p, tick: t, pos5: q, chk5: 1'b1});
      cyc();
      e = sb.pop_front();
      checks++;
      if (pos8 !== 3'(e.pos) || led8 !== 8'(1 << e.pos) || tick8 !== e.tick ||
          pos5 !== 3'(e.pos5) || led5 !== 5'(1 << e.pos5) || tick5 !== e.tick) begin
        errors++;
        $display("FAIL interleave c=%0d: got pos=%0d led=%h tick=%b pos5=%0d led5=%h tick5=%b, want pos=%0d pos5=%0d tick=%b",
                 c, pos8, led8, tick8, pos5, led5, tick5, e.pos, e.pos5, e.tick);
      end
    end
  endtask

  task automatic test_pause_step();
    exp_t e;
    int   p = 0;
    logic t;
    mode = 2'd0; en = 1'b1; step = 1'b0;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      en = 1'b1; step = 1'b0; t = 1'b0;
      if ((c >= 3 && c <= 28) || (c >= 34 && c <= 38)) en = 1'b0;
      if (c == 23 || c == 25 || c == 27 || c == 31 || (c >= 35 && c <= 37)) step = 1'b1;
      if (c == 23 || c == 25 || c == 27 || c == 30 || (c >= 35 && c <= 37) || c == 39) begin
        p = (p + 1) % 8; t = 1'b1;
      end
      sb.push_back('{pos: p, tick: t, pos5: 0, chk5: 1'b0});
      cyc();
      e = sb.pop_front();
      checks++;
      if (pos8 !== 3'(e.pos) || led8 !== 8'(1 << e.pos) || tick8 !== e.tick) begin
        errors++;
        $display("FAIL pause_step c=%0d: got pos=%0d led=%h tick=%b, want pos=%0d led=%h tick=%b",
                 c, pos8, led8, tick8, e.pos, 8'(1 << e.pos), e.tick);
      end
    end
    en = 1'b1; step = 1'b0;
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    int   p = 0;
    logic t;
    mode = 2'd1; en = 1'b1; step = 1'b0;
    do_reset();
    for (int c = 1; c <= 28; c++) begin
      rst = (c == 20);
      t = 1'b0;
      if (c == 20) begin
        p = 0;
      end else if (c % 4 == 0) begin
        p = (c == 4 || c == 24) ? 0 : (p + 7) % 8;
        t = 1'b1;
      end
      sb.push_back('{pos: p, tick: t, pos5: 0, chk5: 1'b0});
      cyc();
      e = sb.pop_front();
      checks++;
      if (pos8 !== 3'(e.pos) || led8 !== 8'(1 << e.pos) || tick8 !== e.tick) begin
        errors++;
        $display("FAIL reset_midrun c=%0d: got pos=%0d led=%h tick=%b, want pos=%0d led=%h tick=%b",
                 c, pos8, led8, tick8, e.pos, 8'(1 << e.pos), e.tick);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_mode_glitch();
    exp_t e;
    int   p = 0;
    logic t;
    mode = 2'd0; en = 1'b1; step = 1'b0;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      if (c == 6) mode = 2'd3;
      if (c == 7) mode = 2'd0;
      t = 1'b0;
      if (c % 4 == 0) begin
        p = (p + 1) % 8; t = 1'b1;
      end
      sb.push_back('{pos: p, tick: t, pos5: 0, chk5: 1'b0});
      cyc();
      e = sb.pop_front();
      checks++;
      if (pos8 !== 3'(e.pos) || led8 !== 8'(1 << e.pos) || tick8 !== e.tick) begin
        errors++;
        $display("FAIL mode_glitch c=%0d: got pos=%0d led=%h tick=%b, want pos=%0d led=%h tick=%b",
                 c, pos8, led8, tick8, e.pos, 8'(1 << e.pos), e.tick);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; step = 1'b0; mode = 2'd0;
    test_reset();
    test_rotate_left();
    test_bounce();
    test_interleave();
    test_pause_step();
    test_reset_midrun();
    test_mode_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
